// File: rtl/sfft_ctrl_pkg.sv
// Shared types and helpers for the stochastic FFT run sequencer.
// Holds the FSM state encoding, the registered control-output bundle,
// the next-state rule and the width helpers used to size the cycle counter.
package sfft_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_WARM = 3'd3,
        S_RUN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Control outputs, all registered and derived from the state being entered
    typedef struct packed {
        logic clr;
        logic loadw;
        logic en;
        logic valid;
        logic busy;
    } ctrl_t;

    // Ceiling log2 for elaboration-time sizing (value 1 -> 0 bits)
    function automatic int clog2_f(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One counter serves the load, warm-up and run phases, so it must hold the
    // largest reload value of the three.
    function automatic int cnt_width(input int bitwidth, input int lat, input int wload);
        return max3(bitwidth + 1, clog2_f(lat + 1), clog2_f(wload + 1));
    endfunction

    // Sequencing rule. Abort beats everything; start is only honoured from
    // IDLE or together with ready in DONE.
    function automatic state_t next_state(
        input state_t cur,
        input logic   cyc_zero,
        input logic   skip_warm,
        input logic   start,
        input logic   ready,
        input logic   abort
    );
        state_t nxt;
        nxt = cur;
        case (cur)
            S_IDLE: if (start) nxt = S_CLR;
            S_CLR:  nxt = S_LOAD;
            S_LOAD: if (cyc_zero) nxt = skip_warm ? S_RUN : S_WARM;
            S_WARM: if (cyc_zero) nxt = S_RUN;
            S_RUN:  if (cyc_zero) nxt = S_DONE;
            S_DONE: if (ready) nxt = start ? S_CLR : S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (abort && cur != S_IDLE) begin
            nxt = S_IDLE;
        end
        return nxt;
    endfunction

    // Output pattern held while in a given state
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c       = '0;
        c.clr   = (s == S_CLR);
        c.loadw = (s == S_LOAD);
        c.en    = (s == S_WARM) || (s == S_RUN);
        c.valid = (s == S_DONE);
        c.busy  = (s != S_IDLE);
        return c;
    endfunction

endpackage

// File: rtl/sfft_ctrl_stream_counter.sv
// Ones counter for a single FFT output bitstream.
// Clear wins over increment; the width is chosen by the parent so that one
// full bitstream period of ones fits without wrapping.
module sfft_stream_counter #(
    parameter int CW = 9
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iClr,
    input  logic          iInc,
    input  logic          iBit,
    output logic [CW-1:0] oCnt
);

    logic [CW-1:0] cnt_reg;

    // Accumulate the stream's ones while the sequencer is in its counting window
    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            cnt_reg <= '0;
        end else if (iInc && iBit) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign oCnt = cnt_reg;

endmodule

// File: rtl/sfft_ctrl.sv
// Run sequencer for the stochastic FFT array: clear, twiddle load, warm-up,
// one bitstream period of counting, then a held result with valid/ready.
module sfft_ctrl
    import sfft_ctrl_pkg::*;
#(
    parameter int BITWIDTH  = 8,
    parameter int NUMINPUTS = 8,
    parameter int LOG2N     = 3,
    parameter int LAT       = LOG2N,
    parameter int WLOAD_CYC = 1,
    parameter int CW        = BITWIDTH + 1
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iStart,
    input  logic                    iAbort,
    input  logic                    iReady,
    input  logic [NUMINPUTS-1:0]    iReal,
    input  logic [NUMINPUTS-1:0]    iImg,
    output logic                    oEn,
    output logic                    oLoadW,
    output logic                    oClr,
    output logic                    oBusy,
    output logic                    oValid,
    output logic [NUMINPUTS*CW-1:0] oCntReal,
    output logic [NUMINPUTS*CW-1:0] oCntImg
);

    localparam int CNTW = cnt_width(BITWIDTH, LAT, WLOAD_CYC);

    // Each phase counts down from (length - 1) to zero, then moves on
    localparam logic [CNTW-1:0] LOAD_RELOAD = CNTW'((WLOAD_CYC > 0) ? WLOAD_CYC - 1 : 0);
    localparam logic [CNTW-1:0] WARM_RELOAD = CNTW'((LAT > 0) ? LAT - 1 : 0);
    localparam logic [CNTW-1:0] RUN_RELOAD  = CNTW'((2 ** BITWIDTH) - 1);
    localparam logic            SKIP_WARM   = (LAT == 0);

    state_t          state_reg;
    state_t          state_next;
    logic [CNTW-1:0] cyc_reg;
    ctrl_t           ctrl_reg;
    logic            cnt_clr;
    logic            cnt_inc;

    function automatic logic [CNTW-1:0] reload_for(input state_t s);
        case (s)
            S_LOAD:  return LOAD_RELOAD;
            S_WARM:  return WARM_RELOAD;
            S_RUN:   return RUN_RELOAD;
            default: return '0;
        endcase
    endfunction

    assign state_next = next_state(state_reg, (cyc_reg == '0), SKIP_WARM,
                                   iStart, iReady, iAbort);

    // FSM, shared cycle counter and registered outputs; the counter reloads on every state entry
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg <= S_IDLE;
            cyc_reg   <= '0;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_for(state_next);
            if (state_next != state_reg) begin
                cyc_reg <= reload_for(state_next);
            end else if (cyc_reg != '0) begin
                cyc_reg <= cyc_reg - CNTW'(1);
            end
        end
    end

    // Counters clear during the CLR cycle and only sample during RUN; an abort
    // freezes them at their current values.
    assign cnt_clr = (state_reg == S_CLR);
    assign cnt_inc = (state_reg == S_RUN) && !iAbort;

    generate
        for (genvar gi = 0; gi < NUMINPUTS; gi++) begin : gen_bin
            sfft_stream_counter #(.CW(CW)) u_real (
                .iClk (iClk),
                .iRst (iRst),
                .iClr (cnt_clr),
                .iInc (cnt_inc),
                .iBit (iReal[gi]),
                .oCnt (oCntReal[gi*CW +: CW])
            );
            sfft_stream_counter #(.CW(CW)) u_img (
                .iClk (iClk),
                .iRst (iRst),
                .iClr (cnt_clr),
                .iInc (cnt_inc),
                .iBit (iImg[gi]),
                .oCnt (oCntImg[gi*CW +: CW])
            );
        end
    endgenerate

    assign oClr   = ctrl_reg.clr;
    assign oLoadW = ctrl_reg.loadw;
    assign oEn    = ctrl_reg.en;
    assign oValid = ctrl_reg.valid;
    assign oBusy  = ctrl_reg.busy;

endmodule

// File: tb/tb_sfft_ctrl.sv
// Randomised scoreboard bench for sfft_ctrl: default instance for the main
// scenarios plus a small-parameter instance for the no-warm-up sweep.
module tb_sfft_ctrl;

    localparam int BW        = 8;
    localparam int NI        = 8;
    localparam int L         = 3;
    localparam int W         = 1;
    localparam int CW        = BW + 1;
    localparam int RUNLEN    = 1 << BW;
    localparam int RUN_FIRST = 1 + W + L + 1;
    localparam int RUN_LAST  = 1 + W + L + RUNLEN;

    localparam int SBW = 4;
    localparam int SNI = 4;
    localparam int SL  = 0;
    localparam int SW  = 3;
    localparam int SCW = SBW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort_s = 1'b0, ready = 1'b0;
    logic [NI-1:0] in_real = '0, in_img = '0;
    logic en, loadw, clr, busy, valid;
    logic [NI*CW-1:0] cnt_real, cnt_img;

    logic s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b0;
    logic [SNI-1:0] s_real = '0, s_img = '0;
    logic s_en, s_loadw, s_clr, s_busy, s_valid;
    logic [SNI*SCW-1:0] s_cnt_real, s_cnt_img;

    sfft_ctrl #(.BITWIDTH(BW), .NUMINPUTS(NI), .LOG2N(3), .LAT(L), .WLOAD_CYC(W), .CW(CW)) dut (
        .iClk(clk), .iRst(rst), .iStart(start), .iAbort(abort_s), .iReady(ready),
        .iReal(in_real), .iImg(in_img), .oEn(en), .oLoadW(loadw), .oClr(clr),
        .oBusy(busy), .oValid(valid), .oCntReal(cnt_real), .oCntImg(cnt_img)
    );

    sfft_ctrl #(.BITWIDTH(SBW), .NUMINPUTS(SNI), .LOG2N(2), .LAT(SL), .WLOAD_CYC(SW), .CW(SCW)) dut_s (
        .iClk(clk), .iRst(rst), .iStart(s_start), .iAbort(s_abort), .iReady(s_ready),
        .iReal(s_real), .iImg(s_img), .oEn(s_en), .oLoadW(s_loadw), .oClr(s_clr),
        .oBusy(s_busy), .oValid(s_valid), .oCntReal(s_cnt_real), .oCntImg(s_cnt_img)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               vcyc;
        logic [NI*CW-1:0] er;
        logic [NI*CW-1:0] ei;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each rising oValid must match the oldest scoreboard entry
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (valid && !valid_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: oValid rose at cycle %0d with no run outstanding", cyc);
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", 128'(cyc), 128'(e.vcyc));
                chk("cnt_real", 128'(cnt_real), 128'(e.er));
                chk("cnt_img", 128'(cnt_img), 128'(e.ei));
            end
        end
        valid_prev = valid;
    end

    // One run. kill_kind: 0 none, 1 abort, 2 reset (asserted during cycle kill_at).
    // Start is issued with ready high so a run begun from DONE is back-to-back.
    task automatic do_run(input int mode, input int kill_at, input int kill_kind,
                          input int start_mid_at, input int hold, input string tag);
        int sum_r[NI];
        int sum_i[NI];
        int seq_bad, first_bad, r, hold_bad;
        logic in_run, exp_clr, exp_lw, exp_en;
        exp_t e;
        seq_bad = 0; first_bad = -1; hold_bad = 0;
        for (int k = 0; k < NI; k++) begin sum_r[k] = 0; sum_i[k] = 0; end
        start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ready = 1'b0;
        for (int c = 1; c <= RUN_LAST; c++) begin
            in_run = (c >= RUN_FIRST) && (c <= RUN_LAST);
            r = c - RUN_FIRST;
            case (mode)
                0: begin in_real = '1; in_img = '0; end
                1: begin
                    if (in_run) begin
                        for (int k = 0; k < NI; k++) in_real[k] = ((r % (k + 2)) == 0);
                        in_img = NI'($urandom);
                    end else begin
                        in_real = '1; in_img = '1;
                    end
                end
                default: begin in_real = NI'($urandom); in_img = NI'($urandom); end
            endcase
            if (in_run) begin
                for (int k = 0; k < NI; k++) begin
                    sum_r[k] += int'(in_real[k]);
                    sum_i[k] += int'(in_img[k]);
                end
            end
            abort_s = (kill_kind == 1) && (c == kill_at);
            rst     = (kill_kind == 2) && (c == kill_at);
            start   = (c == start_mid_at);
            exp_clr = (c == 1);
            exp_lw  = (c >= 2) && (c <= 1 + W);
            exp_en  = (c >= 2 + W) && (c <= RUN_LAST);
            if ({clr, loadw, en, valid, busy} !== {exp_clr, exp_lw, exp_en, 1'b0, 1'b1}) begin
                seq_bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (c == 2) chk({tag, "_cnt_zero_after_clr"}, 128'({cnt_real, cnt_img}), 128'(0));
            if (c == kill_at) begin
                @(posedge clk); #1;
                abort_s = 1'b0; rst = 1'b0; start = 1'b0;
                chk({tag, "_seq_before_kill"}, 128'(seq_bad), 128'(0));
                chk({tag, "_outputs_after_kill"}, 128'({clr, loadw, en, valid, busy}), 128'(0));
                if (kill_kind == 2) chk({tag, "_cnt_after_rst"}, 128'({cnt_real, cnt_img}), 128'(0));
                return;
            end
            if (c == RUN_LAST) begin
                for (int k = 0; k < NI; k++) begin
                    e.er[k*CW +: CW] = (mode == 1) ? CW'((RUNLEN + k + 1) / (k + 2)) : CW'(sum_r[k]);
                    e.ei[k*CW +: CW] = CW'(sum_i[k]);
                end
                e.vcyc = cyc + 1;
                sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (first_bad >= 0) $display("FAIL %s_seq: first bad control cycle %0d", tag, first_bad);
        chk({tag, "_seq"}, 128'(seq_bad), 128'(0));
        chk({tag, "_valid_up"}, 128'({valid, busy, en, loadw, clr}), 128'(5'b11000));
        for (int h = 0; h < hold; h++) begin
            if ({valid, busy, en, loadw, clr} !== 5'b11000 || cnt_real !== e.er || cnt_img !== e.ei)
                hold_bad++;
            @(posedge clk); #1;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 128'(hold_bad), 128'(0));
    endtask

    task automatic accept(input string tag);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        chk({tag, "_after_accept"}, 128'({valid, busy}), 128'(0));
    endtask

    task automatic idle_cycles(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if ({busy, valid, en, loadw, clr} !== 5'b0) bad++;
            @(posedge clk); #1;
        end
        chk({tag, "_stays_idle"}, 128'(bad), 128'(0));
    endtask

    task automatic sweep();
        int lat, bad;
        logic [SNI*SCW-1:0] er, ei;
        lat = 0; bad = 0;
        s_img = SNI'($urandom);
        s_real = '1;
        for (int k = 0; k < SNI; k++) begin
            er[k*SCW +: SCW] = SCW'(16);
            ei[k*SCW +: SCW] = s_img[k] ? SCW'(16) : SCW'(0);
        end
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (s_valid) begin lat = c; break; end
            if ({s_clr, s_loadw, s_en} !== {c == 1, (c >= 2) && (c <= 1 + SW), (c >= 2 + SW) && (c <= 1 + SW + 16)})
                bad++;
            @(posedge clk); #1;
        end
        chk("sweep_latency", 128'(lat), 128'(21));
        chk("sweep_seq", 128'(bad), 128'(0));
        chk("sweep_cnt_real", 128'(s_cnt_real), 128'(er));
        chk("sweep_cnt_img", 128'(s_cnt_img), 128'(ei));
        s_ready = 1'b1;
        @(posedge clk); #1;
        s_ready = 1'b0;
        chk("sweep_after_accept", 128'({s_valid, s_busy}), 128'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_outputs", 128'({clr, loadw, en, valid, busy}), 128'(0));
        chk("reset_counts", 128'({cnt_real, cnt_img}), 128'(0));
        chk("reset_sweep_outputs", 128'({s_clr, s_loadw, s_en, s_valid, s_busy}), 128'(0));

        do_run(0, -1, 0, -1, 0, "ones");
        accept("ones");
        do_run(1, -1, 0, -1, 50, "period");
        do_run(2, -1, 0, -1, 0, "b2b");
        accept("b2b");
        do_run(2, RUN_FIRST + 99, 1, -1, 0, "abort");
        idle_cycles(5, "abort");
        do_run(2, -1, 0, -1, 0, "fresh");
        accept("fresh");
        do_run(2, 2, 2, -1, 0, "rst_load");
        idle_cycles(3, "rst_load");
        do_run(2, -1, 0, RUN_FIRST + 50, 2, "midstart");
        accept("midstart");
        idle_cycles(5, "midstart");
        do_run(0, -1, 0, -1, 3, "rst_done");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_done_outputs", 128'({clr, loadw, en, valid, busy}), 128'(0));
        chk("rst_done_counts", 128'({cnt_real, cnt_img}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        sweep();
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
